// File: rtl/chaotic_iter_scheduler.sv
// Iteration sequencer for the x/y/z forward-Euler chaotic datapath: one iteration in flight,
// results fed back as state and streamed out. Optional burn-in suppression via CHAOS_BURNIN_EN.
module chaotic_iter_scheduler #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32,
  parameter int TIMEOUT    = 300,
  parameter int BURNIN     = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_seed_valid,
  input  logic [DATA_WIDTH-1:0] i_seed_x,
  input  logic [DATA_WIDTH-1:0] i_seed_y,
  input  logic [DATA_WIDTH-1:0] i_seed_z,
  input  logic [CNT_WIDTH-1:0]  i_iter_num,
  input  logic                  i_start,
  input  logic                  i_stop,
  output logic                  o_launch_valid,
  output logic [DATA_WIDTH-1:0] o_xn,
  output logic [DATA_WIDTH-1:0] o_yn,
  output logic [DATA_WIDTH-1:0] o_zn,
  input  logic                  i_xn1_valid,
  input  logic                  i_yn1_valid,
  input  logic                  i_zn1_valid,
  input  logic [DATA_WIDTH-1:0] i_xn1,
  input  logic [DATA_WIDTH-1:0] i_yn1,
  input  logic [DATA_WIDTH-1:0] i_zn1,
  output logic                  o_sample_valid,
  output logic [DATA_WIDTH-1:0] o_sample_x,
  output logic [DATA_WIDTH-1:0] o_sample_y,
  output logic [DATA_WIDTH-1:0] o_sample_z,
  output logic [CNT_WIDTH-1:0]  o_iter_cnt,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE, S_DONE} state_t;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  // r_wd counts WAIT cycles already elapsed, so this value makes err land TIMEOUT cycles after launch.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

`ifdef CHAOS_BURNIN_EN
  localparam bit BURNIN_EN = 1'b1;
`else
  localparam bit BURNIN_EN = 1'b0;
`endif

  state_t                  r_state;
  state_t                  w_state_next;
  logic [DATA_WIDTH-1:0]   r_xn;
  logic [DATA_WIDTH-1:0]   r_yn;
  logic [DATA_WIDTH-1:0]   r_zn;
  logic [CNT_WIDTH-1:0]    r_iter_cnt;
  logic [CNT_WIDTH-1:0]    r_iter_num;
  logic [WD_W-1:0]         r_wd;
  logic                    r_stop_pend;
  logic                    r_err;

  logic                    w_all_valid;
  logic                    w_any_valid;
  logic                    w_timeout;
  logic                    w_stop_req;
  logic [CNT_WIDTH-1:0]    w_cnt_inc;
  logic                    w_last_iter;
  logic                    w_burnin_ok;

  assign w_all_valid = i_xn1_valid & i_yn1_valid & i_zn1_valid;
  assign w_any_valid = i_xn1_valid | i_yn1_valid | i_zn1_valid;
  assign w_timeout   = (r_wd == WD_LAST);
  assign w_stop_req  = r_stop_pend | i_stop;
  assign w_cnt_inc   = r_iter_cnt + 1'b1;
  assign w_last_iter = (r_iter_num != '0) && (w_cnt_inc == r_iter_num);
  assign w_burnin_ok = !BURNIN_EN || (r_iter_cnt >= CNT_WIDTH'(BURNIN));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_state_next = S_LAUNCH;
      S_LAUNCH:  w_state_next = S_WAIT;
      S_WAIT: begin
        if (w_all_valid)                  w_state_next = S_CAPTURE;
        else if (w_any_valid || w_timeout) w_state_next = S_DONE;
      end
      S_CAPTURE: w_state_next = (w_last_iter || w_stop_req) ? S_DONE : S_LAUNCH;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // State regs: seed in IDLE (same-cycle start launches from the new seed), results in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xn <= '0;
      r_yn <= '0;
      r_zn <= '0;
    end else if (r_state == S_IDLE && i_seed_valid) begin
      r_xn <= i_seed_x;
      r_yn <= i_seed_y;
      r_zn <= i_seed_z;
    end else if (r_state == S_WAIT && w_all_valid) begin
      r_xn <= i_xn1;
      r_yn <= i_yn1;
      r_zn <= i_zn1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iter_cnt <= '0;
      r_iter_num <= '0;
      r_err      <= 1'b0;
      r_wd       <= '0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_iter_cnt <= '0;
        r_iter_num <= i_iter_num;
        r_err      <= 1'b0;
      end
      if (r_state == S_LAUNCH) r_wd <= '0;
      if (r_state == S_WAIT) begin
        r_wd <= r_wd + 1'b1;
        if (!w_all_valid && (w_any_valid || w_timeout)) r_err <= 1'b1;
      end
      if (r_state == S_CAPTURE && r_iter_cnt != '1) r_iter_cnt <= w_cnt_inc;
    end
  end

  // A stop is held until the in-flight iteration completes; it is dropped in IDLE and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_stop_pend <= 1'b0;
    else if (r_state == S_IDLE || r_state == S_DONE) r_stop_pend <= 1'b0;
    else if (i_stop)                               r_stop_pend <= 1'b1;
  end

  assign o_launch_valid = (r_state == S_LAUNCH);
  assign o_busy         = (r_state == S_LAUNCH) || (r_state == S_WAIT) || (r_state == S_CAPTURE);
  assign o_done         = (r_state == S_DONE);
  assign o_sample_valid = (r_state == S_CAPTURE) && w_burnin_ok;
  assign o_xn           = r_xn;
  assign o_yn           = r_yn;
  assign o_zn           = r_zn;
  assign o_sample_x     = r_xn;
  assign o_sample_y     = r_yn;
  assign o_sample_z     = r_zn;
  assign o_iter_cnt     = r_iter_cnt;
  assign o_err          = r_err;

endmodule
